// File: rtl/mdu_iter_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
//   master : requester side (drives the op, operands, flush and out_ready_i)
//   slave  : the unit itself (drives in_ready_o, out_valid_o and res_o)
// Signals:
//   flush_i      pipeline kill, abandons whatever the unit is doing
//   in_valid_i   op request;   in_ready_o  unit can accept (IDLE only)
//   op_i         funct3 (0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU)
//   w_i          32-bit W variant
//   src1_i/src2_i rs1 / rs2
//   out_valid_o  result available; out_ready_i consumer takes it
//   res_o        result, stable while out_valid_o && !out_ready_i
interface mdu_iter_if #(
    parameter int XLEN = 64
);
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [2:0]      op_i;
    logic            w_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] res_o;

    modport master (
        output flush_i, in_valid_i, op_i, w_i, src1_i, src2_i, out_ready_i,
        input  in_ready_o, out_valid_o, res_o
    );

    modport slave (
        input  flush_i, in_valid_i, op_i, w_i, src1_i, src2_i, out_ready_i,
        output in_ready_o, out_valid_o, res_o
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit, one bit per cycle.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    mdu_iter_if.slave (request / result handshakes, flush)
// Multiply: shift-add of operand magnitudes into a 2*XLEN accumulator,
// sign applied when the result is registered. Divide: restoring
// shift-subtract on magnitudes. Divide-by-zero, signed overflow and illegal
// W multiplies are resolved straight from IDLE without iterating.
module mdu_iter #(
    parameter int XLEN = 64,
    parameter bit W_EN = 1'b1
) (
    input logic       clock,
    input logic       reset,
    mdu_iter_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    logic [1:0]        state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [2:0]        op_reg;
    logic              w_reg;
    logic              sa_reg;   // operand 1 was negative
    logic              sb_reg;   // operand 2 was negative
    // Multiply: a_reg = shifting multiplicand, b_reg = shifting multiplier,
    //           acc_reg = partial product.
    // Divide:   a_reg[XLEN-1:0] = dividend shifting out / quotient shifting in,
    //           b_reg = divisor, acc_reg[XLEN-1:0] = partial remainder.
    logic [2*XLEN-1:0] a_reg;
    logic [XLEN-1:0]   b_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   res_reg;

    // ---------------- request decode (used in IDLE) ----------------
    logic            w_in;
    logic [2:0]      in_op;
    logic            sgn1, sgn2;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_val, dividend_res;
    logic            neg_a, neg_b, div_zero, ovf, illegal, fast;
    logic [XLEN-1:0] fast_res;

    assign w_in  = W_EN && bus.w_i;
    assign in_op = bus.op_i;
    // MUL low bits do not depend on signedness, so it is treated as signed.
    assign sgn1  = (in_op != 3'd3) && (in_op != 3'd5) && (in_op != 3'd7);
    assign sgn2  = (in_op == 3'd0) || (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);

    assign a_ext = w_in ? (sgn1 ? sext32(bus.src1_i[31:0]) : {{(XLEN-32){1'b0}}, bus.src1_i[31:0]})
                        : bus.src1_i;
    assign b_ext = w_in ? (sgn2 ? sext32(bus.src2_i[31:0]) : {{(XLEN-32){1'b0}}, bus.src2_i[31:0]})
                        : bus.src2_i;
    assign neg_a = sgn1 && a_ext[XLEN-1];
    assign neg_b = sgn2 && b_ext[XLEN-1];
    assign mag_a = neg_a ? -a_ext : a_ext;
    assign mag_b = neg_b ? -b_ext : b_ext;

    assign min_val      = w_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    assign dividend_res = w_in ? sext32(bus.src1_i[31:0]) : bus.src1_i;
    assign div_zero     = in_op[2] && (b_ext == '0);
    assign ovf          = in_op[2] && !in_op[0] && (a_ext == min_val) && (b_ext == '1);
    assign illegal      = w_in && (in_op == 3'd1 || in_op == 3'd2 || in_op == 3'd3);
    assign fast         = div_zero || ovf || illegal;

    always_comb begin
        fast_res = '0;
        if (illegal)       fast_res = '0;
        else if (div_zero) fast_res = in_op[1] ? dividend_res : '1;
        else if (ovf)      fast_res = in_op[1] ? '0 : a_ext;
    end

    // ---------------- one iteration step ----------------
    logic [2*XLEN-1:0] acc_mul, prod;
    logic [XLEN:0]     rem_sh, diff;
    logic              qbit, last;
    logic [XLEN-1:0]   rem_n, quo_n, quo_s, rem_s, full, fin_res;

    assign acc_mul = acc_reg + (b_reg[0] ? a_reg : '0);
    assign rem_sh  = {acc_reg[XLEN-1:0], a_reg[XLEN-1]};
    assign diff    = rem_sh - {1'b0, b_reg};
    assign qbit    = !diff[XLEN];   // no borrow: divisor fits
    assign rem_n   = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_n   = {a_reg[XLEN-2:0], qbit};

    // Final value, formed from the step's next values so the last
    // iteration and the sign fix-up land on the same edge.
    assign prod  = (sa_reg ^ sb_reg) ? -acc_mul : acc_mul;
    assign quo_s = (sa_reg ^ sb_reg) ? -quo_n : quo_n;
    assign rem_s = sa_reg ? -rem_n : rem_n;

    always_comb begin
        full = '0;
        if (op_reg[2])               full = op_reg[1] ? rem_s : quo_s;
        else if (op_reg[1:0] == 2'd0) full = prod[XLEN-1:0];
        else                         full = prod[2*XLEN-1:XLEN];
    end
    assign fin_res = w_reg ? sext32(full[31:0]) : full;
    assign last    = (cnt_reg == (w_reg ? CW'(31) : CW'(XLEN-1)));

    // ---------------- state ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            w_reg     <= 1'b0;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            res_reg   <= '0;
        end else if (bus.flush_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        op_reg  <= in_op;
                        w_reg   <= w_in;
                        sa_reg  <= neg_a;
                        sb_reg  <= neg_b;
                        cnt_reg <= '0;
                        b_reg   <= mag_b;
                        acc_reg <= '0;
                        // W dividends are pre-aligned so their MSB is the
                        // first bit shifted into the remainder.
                        if (in_op[2] && w_in)
                            a_reg <= {{XLEN{1'b0}}, mag_a << (XLEN-32)};
                        else
                            a_reg <= {{XLEN{1'b0}}, mag_a};
                        if (fast) begin
                            res_reg   <= fast_res;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_reg[2]) begin
                        a_reg   <= {{XLEN{1'b0}}, quo_n};
                        acc_reg <= {{XLEN{1'b0}}, rem_n};
                    end else begin
                        a_reg   <= a_reg << 1;
                        b_reg   <= b_reg >> 1;
                        acc_reg <= acc_mul;
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last) begin
                        res_reg   <= fin_res;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (state_reg == IDLE);
    assign bus.out_valid_o = (state_reg == DONE);
    assign bus.res_o       = res_reg;
endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(64)) bus();
    mdu_iter #(.XLEN(64), .W_EN(1'b1)) dut (.clock(clk), .reset(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic straight from the instruction rules.
    function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, p;
        logic [31:0]  a32, b32, r32;
        int           s32a, s32b;
        longint       sa, sb;
        logic [63:0]  MIN64;
        MIN64 = 64'h8000_0000_0000_0000;
        if (w) begin
            a32 = a[31:0]; b32 = b[31:0]; s32a = a32; s32b = b32;
            r32 = '0;
            case (op)
                3'd0: r32 = a32 * b32;
                3'd4: if (b32 == 0) r32 = '1;
                      else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                      else r32 = 32'(s32a / s32b);
                3'd5: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
                3'd6: if (b32 == 0) r32 = a32;
                      else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
                      else r32 = 32'(s32a % s32b);
                3'd7: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
                default: r32 = '0;
            endcase
            return {{32{r32[31]}}, r32};
        end
        sa = a; sb = b;
        case (op)
            3'd0: return a * b;
            3'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
            3'd2: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b};       p = pa * pb; return p[127:64]; end
            3'd3: begin pa = {64'd0, a};       pb = {64'd0, b};       p = pa * pb; return p[127:64]; end
            3'd4: if (b == 0) return '1;
                  else if (a == MIN64 && b == '1) return a;
                  else return 64'(sa / sb);
            3'd5: if (b == 0) return '1; else return a / b;
            3'd6: if (b == 0) return a;
                  else if (a == MIN64 && b == '1) return '0;
                  else return 64'(sa % sb);
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        if (w && op >= 3'd1 && op <= 3'd3) return 1;
        if (op[2]) begin
            if (w) begin
                if (b[31:0] == 0) return 1;
                if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 1;
            end else begin
                if (b == 0) return 1;
                if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
            end
        end
        return w ? 33 : 65;
    endfunction

    // Issue one op, wait (bounded) for the result, then take it.
    task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output int lat);
        @(negedge clk);
        bus.op_i = op; bus.w_i = w; bus.src1_i = a; bus.src2_i = b;
        bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        lat = 0;
        res = '0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid_o) break;
        end
        if (!bus.out_valid_o) begin
            total++; bad++;
            $display("FAIL timeout: got no out_valid expected out_valid within 200 cycles");
        end
        res = bus.res_o;
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.out_ready_i = 1'b0;
        $display("op=%0d w=%0d a=%h b=%h res=%h lat=%0d", op, w, a, b, res, lat);
    endtask

    initial begin
        logic [63:0] res, a, b, prev;
        int          lat;
        logic [2:0]  op;
        logic        w;
        bit          seen;

        vecs[0]  = '{3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65};
        vecs[1]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[2]  = '{3'd2, 1'b0, '1, 64'd2, '1, 65};
        vecs[3]  = '{3'd4, 1'b0, 64'd7, 64'd0, '1, 1};
        vecs[4]  = '{3'd7, 1'b0, 64'd7, 64'd0, 64'd7, 1};
        vecs[5]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
        vecs[6]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
        vecs[7]  = '{3'd4, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[8]  = '{3'd6, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, '1, 33};
        vecs[9]  = '{3'd5, 1'b1, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};
        vecs[10] = '{3'd1, 1'b1, 64'd5, 64'd6, 64'd0, 1};
        vecs[11] = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65};

        bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
        bus.op_i = '0; bus.w_i = 1'b0; bus.src1_i = '0; bus.src2_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("reset_res", bus.res_o, 64'd0);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_res", i), res, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 1000));
            case ($urandom_range(0, 15))
                0, 1: b = '0;
                2, 3: b = 64'($urandom_range(1, 50));
                4:    b = '1;
                default: ;
            endcase
            do_op(op, w, a, b, res, lat);
            check($sformatf("rnd%0d_res", i), res, model(op, w, a, b));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(model_lat(op, w, a, b)));
        end

        // Back-pressure: hold the result for 5 cycles
        @(negedge clk);
        bus.op_i = 3'd0; bus.w_i = 1'b0; bus.src1_i = 64'd6; bus.src2_i = 64'd7;
        bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        lat = 0;
        while (lat < 200 && !bus.out_valid_o) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd65);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", k), 64'(bus.out_valid_o), 64'd1);
            check($sformatf("bp_res%0d", k), bus.res_o, 64'd42);
            check($sformatf("bp_in_ready%0d", k), 64'(bus.in_ready_o), 64'd0);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.out_ready_i = 1'b0;
        @(negedge clk);
        check("bp_no_dup", 64'(bus.out_valid_o), 64'd0);
        check("bp_idle", 64'(bus.in_ready_o), 64'd1);
        $display("backpressure sequence done res=%h", bus.res_o);

        // Flush at cnt=10
        prev = bus.res_o;
        @(negedge clk);
        bus.op_i = 3'd0; bus.src1_i = 64'd11; bus.src2_i = 64'd13; bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("flush_res_kept", bus.res_o, prev);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid_o) seen = 1'b1;
        end
        check("flush_no_result", 64'(seen), 64'd0);
        $display("flush sequence done");

        // Flush together with a request: nothing is accepted
        @(negedge clk);
        bus.op_i = 3'd4; bus.w_i = 1'b0; bus.src1_i = 64'd7; bus.src2_i = 64'd0;
        bus.in_valid_i = 1'b1; bus.flush_i = 1'b1;
        @(posedge clk);
        #1 begin bus.in_valid_i = 1'b0; bus.flush_i = 1'b0; end
        @(negedge clk);
        check("flush_req_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("flush_req_in_ready", 64'(bus.in_ready_o), 64'd1);
        $display("flush+request sequence done");

        // Reset at cnt=20, then a normal op
        @(negedge clk);
        bus.op_i = 3'd5; bus.src1_i = 64'd1000; bus.src2_i = 64'd3; bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("midrst_res", bus.res_o, 64'd0);
        do_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, res, lat);   // -100 rem 7
        check("after_rst_res", res, model(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7));
        check("after_rst_lat", 64'(lat), 64'd65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
